// File: rtl/nw_alignment_emitter_pkg.sv
// ---------------------------------------------------------------------------
// nw_alignment_emitter_pkg
// Shared types for the NW alignment emitter.
//   dir_e     : alignment op encoding, identical to the grid Cell direction
//   state_e   : emitter FSM states
//   step_t    : result of classifying one traceback step
//   *_W       : default scoring weights (must match the grid's weights)
// ---------------------------------------------------------------------------
package nw_alignment_emitter_pkg;

    typedef enum logic [1:0] {
        TOP_DIR    = 2'b00,
        LEFT_DIR   = 2'b01,
        CORNER_DIR = 2'b10
    } dir_e;

    typedef enum logic [1:0] {
        COLLECT,
        EMIT,
        DONE
    } state_e;

    localparam int MATCH_W    = 1;
    localparam int INDEL_W    = -1;
    localparam int MISMATCH_W = -1;

    typedef struct packed {
        logic legal;
        dir_e dir;
    } step_t;

    // Turns the backwards step prev->cur into an op direction. Diagonal is a
    // CORNER, a pure row step is TOP, a pure column step is LEFT; anything
    // else (no movement, jumps) cannot come from a valid traceback.
    function automatic step_t classify_step(input logic dx_one, input logic dx_zero,
                                            input logic dy_one, input logic dy_zero);
        step_t s;
        s.legal = 1'b1;
        s.dir   = CORNER_DIR;
        if (dx_one && dy_one) begin
            s.dir = CORNER_DIR;
        end else if (dx_zero && dy_one) begin
            s.dir = TOP_DIR;
        end else if (dx_one && dy_zero) begin
            s.dir = LEFT_DIR;
        end else begin
            s.legal = 1'b0;
        end
        return s;
    endfunction

endpackage

// File: rtl/nw_alignment_emitter_if.sv
// ---------------------------------------------------------------------------
// nw_alignment_emitter_if
// Handshake bundle of the emitter: the coordinate stream coming from the
// traceback and the aligned-pair stream going to the sink.
//   in_valid/in_ready/in_x/in_y          : coordinate stream
//   out_valid/out_ready/out_op/out_match
//   out_c1/out_c2/out_last               : aligned pair stream
// Modports: slave = the emitter, master = the environment driving it.
// ---------------------------------------------------------------------------
interface nw_alignment_emitter_if #(
    parameter int CWIDTH      = 2,
    parameter int CORD_LENGTH = 8
);
    logic                   in_valid;
    logic                   in_ready;
    logic [CORD_LENGTH-1:0] in_x;
    logic [CORD_LENGTH-1:0] in_y;

    logic                   out_valid;
    logic                   out_ready;
    logic [1:0]             out_op;
    logic                   out_match;
    logic [CWIDTH-1:0]      out_c1;
    logic [CWIDTH-1:0]      out_c2;
    logic                   out_last;

    modport slave (
        input  in_valid, in_x, in_y, out_ready,
        output in_ready, out_valid, out_op, out_match, out_c1, out_c2, out_last
    );

    modport master (
        output in_valid, in_x, in_y, out_ready,
        input  in_ready, out_valid, out_op, out_match, out_c1, out_c2, out_last
    );
endinterface

// File: rtl/nw_alignment_emitter_lifo.sv
// ---------------------------------------------------------------------------
// nw_alignment_emitter_lifo
// Simple register-file stack used to reverse the traceback order.
//   clk, reset : clock, synchronous active-high reset (empties the stack)
//   push       : write push_data on top (ignored when full)
//   pop        : discard the top entry (ignored when empty)
//   top        : current top entry, meaningless when empty
//   count      : number of entries held, 0..DEPTH
//   full/empty : count == DEPTH / count == 0
// push and pop are never asserted together by the emitter.
// ---------------------------------------------------------------------------
module nw_alignment_emitter_lifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    top_idx;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign wr_idx  = AW'(count);
    assign top_idx = AW'(count - CNT_W'(1));
    assign top     = mem[top_idx];

    // Storage needs no reset: count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_idx] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + CNT_W'(1);
        end else if (pop && !empty) begin
            count <= count - CNT_W'(1);
        end
    end
endmodule

// File: rtl/nw_alignment_emitter.sv
// ---------------------------------------------------------------------------
// nw_alignment_emitter
// Takes the traceback coordinate stream, which runs from (LENGTH-1,LENGTH-1)
// down to (0,0), turns each step into an alignment op, stacks the ops and
// replays them in forward order as aligned character pairs while
// recomputing the alignment score.
//   clk, reset : clock, synchronous active-high reset
//   s1, s2     : input strings, char i at [i*CWIDTH +: CWIDTH], held stable
//   bus        : coordinate stream in, aligned pair stream out (slave side)
//   score      : signed recomputed score, held after done until next run
//   done       : one-cycle pulse after the final pair is accepted
//   err        : sticky protocol error flag
// ---------------------------------------------------------------------------
module nw_alignment_emitter
    import nw_alignment_emitter_pkg::*;
#(
    parameter int LENGTH      = 10,
    parameter int CWIDTH      = 2,
    parameter int SWIDTH      = 16,
    parameter int CORD_LENGTH = 8,
    parameter int DEPTH       = 2 * LENGTH,
    parameter int MATCH       = MATCH_W,
    parameter int INDEL       = INDEL_W,
    parameter int MISMATCH    = MISMATCH_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [LENGTH*CWIDTH-1:0]  s1,
    input  logic [LENGTH*CWIDTH-1:0]  s2,
    nw_alignment_emitter_if.slave     bus,
    output logic signed [SWIDTH-1:0]  score,
    output logic                      done,
    output logic                      err
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        dir_e              op;
        logic              match;
        logic [CWIDTH-1:0] c1;
        logic [CWIDTH-1:0] c2;
    } pair_t;

    localparam int PW = $bits(pair_t);

    state_e                 state;
    state_e                 state_next;
    logic                   in_ready_c;
    logic                   done_c;

    logic                   first;
    logic                   fin_pending;
    logic [CORD_LENGTH-1:0] prev_x;
    logic [CORD_LENGTH-1:0] prev_y;
    logic                   accept;
    logic [CORD_LENGTH-1:0] dx;
    logic [CORD_LENGTH-1:0] dy;
    step_t                  step;
    logic                   first_ok;
    logic                   cur_origin;

    logic                   push_req;
    pair_t                  push_pair;
    logic                   lifo_push;
    logic                   lifo_pop;
    pair_t                  lifo_top;
    logic [CNT_W-1:0]       lifo_count;
    logic                   lifo_full;
    logic                   lifo_empty;

    logic                   out_valid_q;
    pair_t                  out_pair_q;
    logic                   out_last_q;
    logic                   load;
    logic                   out_fire;

    // Character lookup with out-of-range indices reading as 0, so a corrupt
    // coordinate can never index past the string.
    function automatic logic [CWIDTH-1:0] char_at(input logic [LENGTH*CWIDTH-1:0] s,
                                                  input logic [CORD_LENGTH-1:0] idx);
        logic [CWIDTH-1:0] c;
        c = '0;
        for (int i = 0; i < LENGTH; i++) begin
            if (idx == CORD_LENGTH'(i)) begin
                c = s[i*CWIDTH +: CWIDTH];
            end
        end
        return c;
    endfunction

    // Builds a pair from a direction and the two raw characters; the gapped
    // side is forced to 0 and match only counts on a CORNER.
    function automatic pair_t make_pair(input dir_e dir, input logic [CWIDTH-1:0] a,
                                        input logic [CWIDTH-1:0] b);
        pair_t p;
        p.op    = dir;
        p.c1    = (dir == LEFT_DIR) ? '0 : a;
        p.c2    = (dir == TOP_DIR)  ? '0 : b;
        p.match = (dir == CORNER_DIR) && (a == b);
        return p;
    endfunction

    function automatic logic signed [SWIDTH-1:0] pair_weight(input pair_t p);
        logic signed [SWIDTH-1:0] w;
        if (p.op == CORNER_DIR) begin
            w = p.match ? SWIDTH'(MATCH) : SWIDTH'(MISMATCH);
        end else begin
            w = SWIDTH'(INDEL);
        end
        return w;
    endfunction

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= COLLECT;
        end else begin
            state <= state_next;
        end
    end

    // FSM next state. EMIT also bails out to DONE if it ever finds nothing to
    // show, so a broken stream can never wedge the block.
    always_comb begin
        state_next = state;
        case (state)
            COLLECT: if (fin_pending) state_next = EMIT;
            EMIT: begin
                if (out_fire && out_last_q) begin
                    state_next = DONE;
                end else if (!out_valid_q && lifo_empty) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // FSM outputs. The cycle that pushes the closing (0,0) CORNER does not
    // take another coordinate.
    always_comb begin
        in_ready_c = 1'b0;
        done_c     = 1'b0;
        case (state)
            COLLECT: in_ready_c = !fin_pending;
            DONE:    done_c     = 1'b1;
            default: ;
        endcase
    end

    assign bus.in_ready = in_ready_c;
    assign done         = done_c;

    assign accept     = bus.in_valid && in_ready_c;
    assign dx         = prev_x - bus.in_x;
    assign dy         = prev_y - bus.in_y;
    assign step       = classify_step(dx == CORD_LENGTH'(1), dx == '0,
                                      dy == CORD_LENGTH'(1), dy == '0);
    assign first_ok   = (bus.in_x == CORD_LENGTH'(LENGTH - 1)) &&
                        (bus.in_y == CORD_LENGTH'(LENGTH - 1));
    assign cur_origin = (bus.in_x == '0) && (bus.in_y == '0);

    // Each accepted step yields the op belonging to the previous coordinate;
    // the origin itself has no successor, so its CORNER goes in one cycle later.
    always_comb begin
        push_req  = 1'b0;
        push_pair = '0;
        if (state == COLLECT) begin
            if (fin_pending) begin
                push_req  = 1'b1;
                push_pair = make_pair(CORNER_DIR, char_at(s1, '0), char_at(s2, '0));
            end else if (accept && !first && step.legal) begin
                push_req  = 1'b1;
                push_pair = make_pair(step.dir, char_at(s1, prev_y), char_at(s2, prev_x));
            end
        end
    end

    assign lifo_push = push_req && !lifo_full;

    // Collection bookkeeping: previous coordinate, run start, score and the
    // sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            first       <= 1'b1;
            fin_pending <= 1'b0;
            prev_x      <= '0;
            prev_y      <= '0;
            score       <= '0;
            err         <= 1'b0;
        end else begin
            if (state == DONE) begin
                first <= 1'b1;
            end
            if (fin_pending) begin
                fin_pending <= 1'b0;
            end
            if (accept) begin
                prev_x <= bus.in_x;
                prev_y <= bus.in_y;
                if (cur_origin) begin
                    fin_pending <= 1'b1;
                end
                if (first) begin
                    first <= 1'b0;
                    score <= '0;
                    if (!first_ok) begin
                        err <= 1'b1;
                    end
                end else if (!step.legal) begin
                    err <= 1'b1;
                end
            end
            if (push_req && lifo_full) begin
                err <= 1'b1;
            end
            if (lifo_push) begin
                score <= score + pair_weight(push_pair);
            end
        end
    end

    nw_alignment_emitter_lifo #(
        .WIDTH (PW),
        .DEPTH (DEPTH)
    ) u_lifo (
        .clk       (clk),
        .reset     (reset),
        .push      (lifo_push),
        .pop       (lifo_pop),
        .push_data (push_pair),
        .top       (lifo_top),
        .count     (lifo_count),
        .full      (lifo_full),
        .empty     (lifo_empty)
    );

    // The output register is refilled straight from the stack top whenever it
    // is empty or being drained, so back-to-back pairs flow without bubbles.
    // The entry that leaves last was pushed first, i.e. the highest indices.
    assign out_fire = out_valid_q && bus.out_ready;
    assign load     = (state == EMIT) && !lifo_empty && (!out_valid_q || bus.out_ready);
    assign lifo_pop = load;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            out_pair_q  <= '0;
            out_last_q  <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            out_pair_q  <= lifo_top;
            out_last_q  <= (lifo_count == CNT_W'(1));
        end else if (out_fire) begin
            out_valid_q <= 1'b0;
            out_pair_q  <= '0;
            out_last_q  <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_op    = out_pair_q.op;
    assign bus.out_match = out_pair_q.match;
    assign bus.out_c1    = out_pair_q.c1;
    assign bus.out_c2    = out_pair_q.c2;
    assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_nw_alignment_emitter.sv
// ---------------------------------------------------------------------------
// tb_nw_alignment_emitter
// Directed bench for nw_alignment_emitter with LENGTH=4. Stimulus tasks feed
// traceback paths and push hand-computed pairs into a scoreboard queue; an
// independent monitor pops and compares each pair the DUT hands over, and
// checks that a stalled pair does not change.
// ---------------------------------------------------------------------------
module tb_nw_alignment_emitter;
    import nw_alignment_emitter_pkg::*;

    localparam int LENGTH      = 4;
    localparam int CWIDTH      = 2;
    localparam int SWIDTH      = 16;
    localparam int CORD_LENGTH = 8;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [LENGTH*CWIDTH-1:0] s1;
    logic [LENGTH*CWIDTH-1:0] s2;
    logic signed [SWIDTH-1:0] score;
    logic                     done;
    logic                     err;

    nw_alignment_emitter_if #(.CWIDTH(CWIDTH), .CORD_LENGTH(CORD_LENGTH)) bus ();

    nw_alignment_emitter #(
        .LENGTH      (LENGTH),
        .CWIDTH      (CWIDTH),
        .SWIDTH      (SWIDTH),
        .CORD_LENGTH (CORD_LENGTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .s1    (s1),
        .s2    (s2),
        .bus   (bus),
        .score (score),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    // Pair code: {last, op[1:0], match, c1[1:0], c2[1:0]}
    int  exp_q[$];
    int  path_x[$];
    int  path_y[$];
    int  checks = 0;
    int  errors = 0;
    bit  sb_enable = 1'b0;
    int  accepted_cnt = 0;
    int  stall_idx = -1;
    int  stall_left = 0;
    bit  hold_ready = 1'b0;

    function automatic int pair_code(int op, int match, int c1, int c2, int last);
        return (last << 7) | (op << 5) | (match << 4) | (c1 << 2) | c2;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic add_pair(input int op, input int match, input int c1, input int c2,
                            input int last);
        exp_q.push_back(pair_code(op, match, c1, c2, last));
    endtask

    // Sink: ready unless held off globally or stalling a chosen pair.
    initial begin
        bus.out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_ready) begin
                bus.out_ready = 1'b0;
            end else if (bus.out_valid && accepted_cnt == stall_idx && stall_left > 0) begin
                bus.out_ready = 1'b0;
                stall_left--;
            end else begin
                bus.out_ready = 1'b1;
            end
        end
    end

    // Monitor: compares accepted pairs against the scoreboard and checks that
    // a pair waiting for ready stays put.
    initial begin
        bit stalled;
        int saved;
        int cur;
        stalled = 1'b0;
        saved   = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                stalled = 1'b0;
            end else begin
                cur = pair_code(int'(bus.out_op), int'(bus.out_match), int'(bus.out_c1),
                                int'(bus.out_c2), int'(bus.out_last));
                if (stalled) begin
                    if (bus.out_valid) checkOutput("hold_stable", cur, saved);
                    else               checkOutput("hold_valid", 0, 1);
                end
                if (bus.out_valid && bus.out_ready) begin
                    if (sb_enable) begin
                        if (exp_q.size() == 0) begin
                            checkOutput("unexpected_pair", cur, -1);
                        end else begin
                            checkOutput($sformatf("pair%0d", accepted_cnt), cur, exp_q.pop_front());
                        end
                    end
                    accepted_cnt++;
                    stalled = 1'b0;
                end else if (bus.out_valid) begin
                    stalled = 1'b1;
                    saved   = cur;
                end else begin
                    stalled = 1'b0;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        accepted_cnt = 0;
        stall_idx    = -1;
        stall_left   = 0;
        reset        = 1'b0;
    endtask

    task automatic send_coord(input int x, input int y);
        int t;
        t = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_x     = CORD_LENGTH'(x);
        bus.in_y     = CORD_LENGTH'(y);
        while (!bus.in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) checkOutput("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    // Sends path_x/path_y; if err_beat >= 0, err must be set right after it.
    task automatic applyStimulus(input int err_beat);
        for (int i = 0; i < path_x.size(); i++) begin
            send_coord(path_x[i], path_y[i]);
            if (i == err_beat) begin
                @(negedge clk);
                checkOutput($sformatf("err_after_beat%0d", i), int'(err), 1);
            end
        end
    endtask

    task automatic finishRun(input int exp_err, input bit chk_score, input int exp_score,
                             input int exp_pairs);
        int t;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!done && t < 300);
        checkOutput("done_seen", int'(done), 1);
        checkOutput("err_at_done", int'(err), exp_err);
        if (chk_score) checkOutput("score", int'(score), exp_score);
        checkOutput("pairs_accepted", accepted_cnt, exp_pairs);
        if (sb_enable) checkOutput("queue_left", exp_q.size(), 0);
        @(negedge clk);
        checkOutput("done_pulse_width", int'(done), 0);
        checkOutput("in_ready_after_done", int'(bus.in_ready), 1);
        accepted_cnt = 0;
    endtask

    task automatic load_test1();
        s1     = 8'hE4;
        s2     = 8'hE4;
        path_x = '{3, 2, 1, 0};
        path_y = '{3, 2, 1, 0};
        add_pair(2, 1, 0, 0, 0);
        add_pair(2, 1, 1, 1, 0);
        add_pair(2, 1, 2, 2, 0);
        add_pair(2, 1, 3, 3, 1);
    endtask

    initial begin
        int t;
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        s1           = '0;
        s2           = '0;
        do_reset();

        checkOutput("rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("rst_score", int'(score), 0);
        checkOutput("rst_done", int'(done), 0);
        checkOutput("rst_err", int'(err), 0);

        $display("[TB] test 1: identical strings");
        sb_enable = 1'b1;
        load_test1();
        applyStimulus(-1);
        finishRun(0, 1'b1, 4, 4);

        $display("[TB] test 2: gapped path");
        checkOutput("score_held", int'(score), 4);
        s1     = 8'h90;
        s2     = 8'hE4;
        path_x = '{3, 2, 1, 0, 0};
        path_y = '{3, 3, 2, 1, 0};
        add_pair(2, 1, 0, 0, 0);
        add_pair(0, 0, 0, 0, 0);
        add_pair(2, 1, 1, 1, 0);
        add_pair(2, 1, 2, 2, 0);
        add_pair(1, 0, 0, 3, 1);
        applyStimulus(-1);
        finishRun(0, 1'b1, 1, 5);

        $display("[TB] test 5: sink stall on pair 2");
        load_test1();
        stall_idx  = 1;
        stall_left = 5;
        applyStimulus(-1);
        finishRun(0, 1'b1, 4, 4);
        checkOutput("stall_consumed", stall_left, 0);
        stall_idx = -1;

        $display("[TB] test 3: illegal step");
        sb_enable = 1'b0;
        s1        = 8'hE4;
        s2        = 8'hE4;
        path_x    = '{3, 1, 0, 0, 0};
        path_y    = '{3, 3, 2, 1, 0};
        applyStimulus(1);
        finishRun(1, 1'b0, 0, 4);

        $display("[TB] test 4: wrong first coordinate");
        do_reset();
        checkOutput("err_cleared", int'(err), 0);
        path_x = '{2, 1, 0, 0};
        path_y = '{3, 2, 1, 0};
        applyStimulus(0);
        finishRun(1, 1'b0, 0, 4);

        $display("[TB] test 6: reset during EMIT");
        do_reset();
        hold_ready = 1'b1;
        s1         = 8'hE4;
        s2         = 8'hE4;
        path_x     = '{3, 2, 1, 0};
        path_y     = '{3, 2, 1, 0};
        applyStimulus(-1);
        t = 0;
        while (!bus.out_valid && t < 50) begin
            @(negedge clk);
            t++;
        end
        checkOutput("emit_valid", int'(bus.out_valid), 1);
        checkOutput("score_before_reset", int'(score), 4);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("mid_rst_out_valid", int'(bus.out_valid), 0);
        checkOutput("mid_rst_in_ready", int'(bus.in_ready), 1);
        checkOutput("mid_rst_err", int'(err), 0);
        checkOutput("mid_rst_score", int'(score), 0);
        accepted_cnt = 0;
        exp_q.delete();
        hold_ready   = 1'b0;
        reset        = 1'b0;

        sb_enable = 1'b1;
        load_test1();
        applyStimulus(-1);
        finishRun(0, 1'b1, 4, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "[TB] watchdog");
    end
endmodule
